iob_fifo_ptr_ctrl: RTL and testbench

Single-clock FIFO pointer controller that sequences the write and read pointers of a 2^ADDR_W-entry FIFO and arbitrates simultaneous push/pop requests against occupancy. It keeps binary and Gray-coded pointers, drives RAM addresses, and produces registered full/empty/almost flags, fill level and sticky overflow/underflow errors. It sits between the FIFO wrapper logic and its dual-port RAM. Its Gray pointer outputs are the ones later handed to dual-clock synchronizers.

---
 rtl/iob_fifo_ptr_ctrl_if.sv | 41 ++++
 rtl/iob_fifo_ptr_ctrl.sv | 105 ++++++++++
 tb/tb_iob_fifo_ptr_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/iob_fifo_ptr_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iob_fifo_ptr_ctrl_if                                               |
// | Request/status bundle between FIFO wrapper and pointer controller  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface iob_fifo_ptr_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              cke_i;
  logic              w_en_i;
  logic              r_en_i;
  logic              w_full_o;
  logic              r_empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [ADDR_W:0]   level_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [ADDR_W-1:0] r_addr_o;
  logic [ADDR_W:0]   w_ptr_gray_o;
  logic [ADDR_W:0]   r_ptr_gray_o;
  logic              w_ack_o;
  logic              r_ack_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output cke_i, w_en_i, r_en_i,
    input  w_full_o, r_empty_o, almost_full_o, almost_empty_o, level_o,
           w_addr_o, r_addr_o, w_ptr_gray_o, r_ptr_gray_o,
           w_ack_o, r_ack_o, overflow_o, underflow_o
  );

  modport slave (
    input  cke_i, w_en_i, r_en_i,
    output w_full_o, r_empty_o, almost_full_o, almost_empty_o, level_o,
           w_addr_o, r_addr_o, w_ptr_gray_o, r_ptr_gray_o,
           w_ack_o, r_ack_o, overflow_o, underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_fifo_ptr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iob_fifo_ptr_ctrl                                                  |
// | Single-clock FIFO pointer/flag controller with Gray pointer outputs|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iob_fifo_ptr_ctrl #(
  parameter int ADDR_W           = 4,
  parameter int ALMOST_FULL_LVL  = 2**ADDR_W - 1,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  wire logic           clk_i,
  input  wire logic           arst_n_i,
  input  wire logic           rst_i,
  iob_fifo_ptr_ctrl_if.slave  bus
);
  localparam logic [ADDR_W:0] c_af_lvl = (ADDR_W+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_W:0] c_ae_lvl = (ADDR_W+1)'(ALMOST_EMPTY_LVL);
  localparam logic            c_af_rst = (c_af_lvl == '0);

  logic [ADDR_W:0] r_w_bin, r_r_bin, r_w_gray, r_r_gray, r_level;
  logic            r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;

  logic            w_w_ack, w_r_ack;
  logic [ADDR_W:0] w_w_bin_nxt, w_r_bin_nxt, w_w_gray_nxt, w_r_gray_nxt, w_level_nxt;
  logic            w_full_nxt;

  assign w_w_ack = bus.cke_i & bus.w_en_i & ~r_full  & ~rst_i;
  assign w_r_ack = bus.cke_i & bus.r_en_i & ~r_empty & ~rst_i;

  assign w_w_bin_nxt  = r_w_bin + {{ADDR_W{1'b0}}, w_w_ack};
  assign w_r_bin_nxt  = r_r_bin + {{ADDR_W{1'b0}}, w_r_ack};
  assign w_w_gray_nxt = w_w_bin_nxt ^ (w_w_bin_nxt >> 1);
  assign w_r_gray_nxt = w_r_bin_nxt ^ (w_r_bin_nxt >> 1);
  assign w_level_nxt  = w_w_bin_nxt - w_r_bin_nxt;

  // Full: Gray pointers differ in exactly the top two bits (all bits when ADDR_W is 1).
  generate
    if (ADDR_W == 1) begin : g_full_w1
      assign w_full_nxt = (w_w_gray_nxt == ~w_r_gray_nxt);
    end else begin : g_full_wn
      assign w_full_nxt = (w_w_gray_nxt ==
                           {~w_r_gray_nxt[ADDR_W:ADDR_W-1], w_r_gray_nxt[ADDR_W-2:0]});
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_w_bin  <= '0;
      r_r_bin  <= '0;
      r_w_gray <= '0;
      r_r_gray <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= c_af_rst;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (bus.cke_i) begin
      if (rst_i) begin
        r_w_bin  <= '0;
        r_r_bin  <= '0;
        r_w_gray <= '0;
        r_r_gray <= '0;
        r_level  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
        r_afull  <= c_af_rst;
        r_aempty <= 1'b1;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        r_w_bin  <= w_w_bin_nxt;
        r_r_bin  <= w_r_bin_nxt;
        r_w_gray <= w_w_gray_nxt;
        r_r_gray <= w_r_gray_nxt;
        r_level  <= w_level_nxt;
        r_full   <= w_full_nxt;
        r_empty  <= (w_w_gray_nxt == w_r_gray_nxt);
        r_afull  <= (w_level_nxt >= c_af_lvl);
        r_aempty <= (w_level_nxt <= c_ae_lvl);
        // Errors are sticky: a rejected request latches until a clear.
        if (bus.w_en_i && r_full)  r_ovf <= 1'b1;
        if (bus.r_en_i && r_empty) r_udf <= 1'b1;
      end
    end
  end

  assign bus.w_ack_o        = w_w_ack;
  assign bus.r_ack_o        = w_r_ack;
  assign bus.w_full_o       = r_full;
  assign bus.r_empty_o      = r_empty;
  assign bus.almost_full_o  = r_afull;
  assign bus.almost_empty_o = r_aempty;
  assign bus.level_o        = r_level;
  assign bus.w_addr_o       = r_w_bin[ADDR_W-1:0];
  assign bus.r_addr_o       = r_r_bin[ADDR_W-1:0];
  assign bus.w_ptr_gray_o   = r_w_gray;
  assign bus.r_ptr_gray_o   = r_r_gray;
  assign bus.overflow_o     = r_ovf;
  assign bus.underflow_o    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_iob_fifo_ptr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_iob_fifo_ptr_ctrl                                               |
// | Scoreboard bench for the FIFO pointer controller, ADDR_W = 2       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_iob_fifo_ptr_ctrl;
  logic clk = 1'b0;
  logic arst_n_i;
  logic rst_i;

  iob_fifo_ptr_ctrl_if #(.ADDR_W(2)) bus ();

  iob_fifo_ptr_ctrl #(
    .ADDR_W(2), .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .rst_i(rst_i), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wack, rack;
    logic [2:0] lvl, wg, rg;
    logic [1:0] wa, ra;
    logic       full, empty, af, ae, ovf, udf;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   busy   = 1'b0;

  int m_cnt = 0, m_w = 0, m_r = 0;
  bit m_ovf = 1'b0, m_udf = 1'b0;
  logic [2:0] gray_tbl [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the bench model predicts acks and the next state.
  task automatic step(input bit w, input bit r, input bit c = 1'b1, input bit s = 1'b0);
    exp_t e;
    bit   full, empty;
    full   = (m_cnt == 4);
    empty  = (m_cnt == 0);
    e.wack = c & w & ~full & ~s;
    e.rack = c & r & ~empty & ~s;
    if (c) begin
      if (s) begin
        m_w = 0; m_r = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
        if (w && full)  m_ovf = 1'b1;
        if (r && empty) m_udf = 1'b1;
        if (e.wack) begin m_w = (m_w + 1) % 8; m_cnt++; end
        if (e.rack) begin m_r = (m_r + 1) % 8; m_cnt--; end
      end
    end
    e.lvl   = 3'(m_cnt);
    e.wg    = gray_tbl[m_w];
    e.rg    = gray_tbl[m_r];
    e.wa    = 2'(m_w % 4);
    e.ra    = 2'(m_r % 4);
    e.full  = (m_cnt == 4);
    e.empty = (m_cnt == 0);
    e.af    = (m_cnt >= 3);
    e.ae    = (m_cnt <= 1);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    q.push_back(e);
    bus.w_en_i = w;
    bus.r_en_i = r;
    bus.cke_i  = c;
    rst_i      = s;
    @(posedge clk); #1;
  endtask

  // Monitor: acks mid-cycle, registered state just after the following edge.
  initial begin : monitor
    exp_t       e;
    logic [2:0] pre_wg, pre_rg;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        busy = 1'b1;
        e = q.pop_front();
        chk("w_ack", 32'(bus.w_ack_o), 32'(e.wack));
        chk("r_ack", 32'(bus.r_ack_o), 32'(e.rack));
        pre_wg = bus.w_ptr_gray_o;
        pre_rg = bus.r_ptr_gray_o;
        @(posedge clk); #2;
        chk("level",    32'(bus.level_o),        32'(e.lvl));
        chk("w_gray",   32'(bus.w_ptr_gray_o),   32'(e.wg));
        chk("r_gray",   32'(bus.r_ptr_gray_o),   32'(e.rg));
        chk("w_addr",   32'(bus.w_addr_o),       32'(e.wa));
        chk("r_addr",   32'(bus.r_addr_o),       32'(e.ra));
        chk("w_full",   32'(bus.w_full_o),       32'(e.full));
        chk("r_empty",  32'(bus.r_empty_o),      32'(e.empty));
        chk("a_full",   32'(bus.almost_full_o),  32'(e.af));
        chk("a_empty",  32'(bus.almost_empty_o), 32'(e.ae));
        chk("overflow", 32'(bus.overflow_o),     32'(e.ovf));
        chk("underflw", 32'(bus.underflow_o),    32'(e.udf));
        if (e.wack) chk("w_gray_hd", $countones(pre_wg ^ bus.w_ptr_gray_o), 1);
        if (e.rack) chk("r_gray_hd", $countones(pre_rg ^ bus.r_ptr_gray_o), 1);
        busy = 1'b0;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || busy) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0 || busy) chk("drain_timeout", 32'(q.size()), 0);
  endtask

  initial begin : driver
    arst_n_i   = 1'b0;
    rst_i      = 1'b0;
    bus.cke_i  = 1'b1;
    bus.w_en_i = 1'b0;
    bus.r_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n_i = 1'b1;

    chk("rst_empty", 32'(bus.r_empty_o), 1);
    chk("rst_full",  32'(bus.w_full_o), 0);
    chk("rst_level", 32'(bus.level_o), 0);
    chk("rst_aempt", 32'(bus.almost_empty_o), 1);
    step(0, 0);

    // Fill then drain
    repeat (4) step(1, 0);
    chk("fill_full",  32'(bus.w_full_o), 1);
    chk("fill_level", 32'(bus.level_o), 4);
    chk("fill_waddr", 32'(bus.w_addr_o), 0);
    chk("fill_wgray", 32'(bus.w_ptr_gray_o), 32'(3'b110));
    repeat (4) step(0, 1);
    chk("drain_empty", 32'(bus.r_empty_o), 1);
    chk("drain_level", 32'(bus.level_o), 0);

    // Simultaneous push/pop at level 2
    repeat (2) step(1, 0);
    repeat (10) step(1, 1);
    chk("sim_level", 32'(bus.level_o), 2);

    // Push+pop while full: only the pop lands
    repeat (2) step(1, 0);
    step(1, 1);
    chk("full_pp_ovf",   32'(bus.overflow_o), 1);
    chk("full_pp_level", 32'(bus.level_o), 3);

    // Underflow and sticky behaviour, then synchronous clear
    repeat (3) step(0, 1);
    step(0, 1);
    step(0, 0);
    chk("udf_sticky", 32'(bus.underflow_o), 1);
    step(0, 0, 1'b1, 1'b1);
    chk("udf_clear", 32'(bus.underflow_o), 0);

    // Wrap through several pointer MSB toggles
    repeat (20) begin
      step(1, 0);
      step(0, 1);
    end

    // Clock enable low at full
    step(0, 0, 1'b1, 1'b1);
    repeat (4) step(1, 0);
    repeat (3) step(1, 1, 1'b0);
    chk("cke_ovf", 32'(bus.overflow_o), 0);
    chk("cke_lvl", 32'(bus.level_o), 4);

    // Level 3 with overflow set, then asynchronous reset without a clock edge
    step(1, 0);
    step(0, 1);
    bus.w_en_i = 1'b0;
    bus.r_en_i = 1'b0;
    drain();
    chk("pre_arst_lvl", 32'(bus.level_o), 3);
    @(negedge clk); #2;
    arst_n_i = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.r_empty_o), 1);
    chk("arst_full",  32'(bus.w_full_o), 0);
    chk("arst_level", 32'(bus.level_o), 0);
    chk("arst_wgray", 32'(bus.w_ptr_gray_o), 0);
    chk("arst_rgray", 32'(bus.r_ptr_gray_o), 0);
    chk("arst_ovf",   32'(bus.overflow_o), 0);
    chk("arst_udf",   32'(bus.underflow_o), 0);
    m_w = 0; m_r = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    arst_n_i = 1'b1;
    step(1, 0);
    step(0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
